instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifq_fifo.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default widths and queue depth
//   - fetch controller state enum (IDLE, RUN, DRAIN)
//   - prefetch queue entry layout {pc, instr} at the default widths
// ---------------------------------------------------------------------------
package ifetch_pkg;

   localparam int PC_W_DEF   = 5;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [PC_W_DEF-1:0]   pc;
      logic [DATA_W_DEF-1:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
// Prefetch queue: DEPTH-entry circular FIFO of fetched instructions.
// Push and pop may happen in the same cycle at any occupancy; a push while
// full is accepted only when a pop frees the head entry in that cycle.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         drop all entries (redirect)
//   push_i, din_i   write an entry at the tail
//   pop_i           remove the head entry
//   dout_o          head entry (valid when !empty_o)
//   full_o, empty_o, count_o   occupancy status
// ---------------------------------------------------------------------------
module ifq_fifo
   import ifetch_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = ifq_entry_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  entry_t                 din_i,
   input  logic                   pop_i,
   output entry_t                 dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   entry_t            mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Issues sequential word fetches to instruction memory, buffers in-order
// responses with their PC in a prefetch queue and hands them to decode.
// A redirect flushes the queue, retargets the fetch PC and squashes all
// in-flight responses (DRAIN until they have returned).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order fetch response
//   redirect_valid/pc                taken branch: flush and refetch
//   instr_valid/data/pc, instr_ready instruction hand-off to decode
// Build option: define IFETCH_BYPASS_EN to forward a live response straight
// to decode in the same cycle when the queue is empty.
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [PC_W-1:0]   instr_pc,
   input  logic              instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

   ifu_state_e      state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   stale_q, stale_d;

   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    fifo_din, fifo_head;
   logic            req_fire, room, rsp_live, bypass_hit;

   // Requests are throttled so every in-flight response has a queue slot.
   assign room           = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_C;
   assign imem_req_valid = (state_q == RUN) && !redirect_valid && room;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is live only if it was not squashed by an earlier or a
   // same-cycle redirect. rsp_pc_q tracks the PC of the next live response.
   assign rsp_live = imem_rsp_valid && !redirect_valid && (stale_q == '0);
   assign fifo_din = '{pc: rsp_pc_q, instr: imem_rsp_data};
   assign fifo_pop = instr_ready && !fifo_empty;

`ifdef IFETCH_BYPASS_EN
   assign bypass_hit = rsp_live && fifo_empty;
   assign fifo_push  = rsp_live && !(bypass_hit && instr_ready);
`else
   assign bypass_hit = 1'b0;
   assign fifo_push  = rsp_live;
`endif

   ifq_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_ifq (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (redirect_valid),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      instr_valid = 1'b0;
      instr_data  = '0;
      instr_pc    = '0;
      if (!fifo_empty) begin
         instr_valid = 1'b1;
         instr_data  = fifo_head.instr;
         instr_pc    = fifo_head.pc;
      end else if (bypass_hit) begin
         instr_valid = 1'b1;
         instr_data  = imem_rsp_data;
         instr_pc    = rsp_pc_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      stale_d    = stale_q;

      unique case ({req_fire, imem_rsp_valid})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: ;
      endcase

      if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (rsp_live) rsp_pc_d   = rsp_pc_q + PC_W'(1);

      unique case (state_q)
         IDLE: begin
            state_d = RUN;
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               rsp_pc_d   = redirect_pc;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               rsp_pc_d   = redirect_pc;
               // No request fires during a redirect, so everything still
               // outstanding after this cycle's response is stale.
               stale_d    = outst_d;
               state_d    = (outst_d != '0) ? DRAIN : RUN;
            end
         end
         DRAIN: begin
            if (imem_rsp_valid) stale_d = stale_q - CW'(1);
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               rsp_pc_d   = redirect_pc;
            end
            if (stale_d == '0) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         rsp_pc_q   <= '0;
         outst_q    <= '0;
         stale_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
      end
   end

   // A live response must always find a free slot (or a same-cycle pop).
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with an in-order instruction memory model whose
// contents are random (Mem[0] = 32'h0062E233). The reference model is the
// program-order stream: requests must walk PC, PC+1, ... (mod 32) from 0 or
// from the latest redirect target, and decode must receive exactly
// (pc, Mem[pc]) in that same order. Directed steps cover reset, first-fetch
// latency, full queue, redirect/drain, PC wrap and simultaneous push/pop,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [4:0]  imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [4:0]  redirect_pc;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [4:0]  instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   logic [31:0] mem [32];
   logic [4:0]  mq [$];        // addresses accepted by memory, not yet answered
   logic [4:0]  exp_req_pc;    // next address the program order requires
   logic [4:0]  exp_ins_pc;    // next PC decode must receive
   int          total, bad, nfire;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply this cycle's inputs; memory answers the oldest pending request.
   task automatic drive(input bit r, input logic [4:0] rp, input bit ir,
                        input bit rdy, input bit ren);
      redirect_valid = r;
      redirect_pc    = rp;
      instr_ready    = ir;
      imem_req_ready = rdy;
      if (!rst && ren && mq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem[mq[0]];
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
   endtask

   // Score the settled cycle, advance the clock, update the memory model.
   task automatic tick();
      bit         fire, rsp, cons;
      logic [4:0] a;
      fire = imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      rsp  = imem_rsp_valid;
      cons = instr_valid && instr_ready;
      if (!rst) begin
         if (fire) begin
            chk("req_addr", 32'(a), 32'(exp_req_pc));
            chk("inflight_bound", 32'(mq.size() < 4), 32'd1);
            exp_req_pc = exp_req_pc + 5'd1;
            nfire++;
         end
         if (cons && !redirect_valid) begin
            chk("instr_pc", 32'(instr_pc), 32'(exp_ins_pc));
            chk("instr_data", instr_data, mem[exp_ins_pc]);
            exp_ins_pc = exp_ins_pc + 5'd1;
         end
         if (redirect_valid) begin
            exp_req_pc = redirect_pc;
            exp_ins_pc = redirect_pc;
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         exp_req_pc = 5'd0;
         exp_ins_pc = 5'd0;
      end else begin
         if (rsp)  void'(mq.pop_front());
         if (fire) mq.push_back(a);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      nfire = 0;
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
         tick();
      end
   endtask

   initial begin
      bit seen;
      total = 0; bad = 0; nfire = 0;
      exp_req_pc = 5'd0; exp_ins_pc = 5'd0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h0062E233;
      rst = 1'b1;

      // Reset values, with a redirect that reset must override
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", 32'(imem_req_addr), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_data", instr_data, 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      tick();
      rst = 1'b0;

      // First fetch: IDLE cycle, request addr 0, then response latency
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("idle_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", 32'(imem_req_addr), 32'd0);
      tick();
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("first_rsp_present", 32'(imem_rsp_valid), 32'd1);
`ifdef IFETCH_BYPASS_EN
      chk("bypass_valid", 32'(instr_valid), 32'd1);
      chk("bypass_pc", 32'(instr_pc), 32'd0);
      chk("bypass_data", instr_data, 32'h0062E233);
`else
      chk("no_bypass_valid", 32'(instr_valid), 32'd0);
`endif
      tick();
`ifndef IFETCH_BYPASS_EN
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("first_instr_valid", 32'(instr_valid), 32'd1);
      chk("first_instr_pc", 32'(instr_pc), 32'd0);
      chk("first_instr_data", instr_data, 32'h0062E233);
      tick();
`endif
      stream(20);

      // Decode stalled: exactly DEPTH requests, queue full, nothing lost
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
         tick();
      end
      chk("full_req_count", 32'(nfire), 32'd4);
      drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      chk("full_no_req", 32'(imem_req_valid), 32'd0);
      chk("full_head_valid", 32'(instr_valid), 32'd1);
      chk("full_head_pc", 32'(instr_pc), 32'd0);
      tick();
      stream(12);

      // Push and pop in the same cycle at high occupancy keep the count
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      chk("hold_req_count", 32'(nfire), 32'd4);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
         tick();
      end
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("pushpop_no_req", 32'(imem_req_valid), 32'd0);
      chk("pushpop_head_pc", 32'(instr_pc), 32'd0);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("after_pushpop_req", 32'(imem_req_valid), 32'd1);
      chk("after_pushpop_head", 32'(instr_pc), 32'd1);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("occupancy_kept", 32'(imem_req_valid), 32'd0);
      tick();
      stream(12);

      // Redirect with two requests outstanding
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
         tick();
      end
      chk("redir_outstanding", 32'(mq.size()), 32'd2);
      drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
      chk("redir_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
         chk("drain_instr_valid", 32'(instr_valid), 32'd0);
         chk("drain_no_req", 32'(imem_req_valid), 32'd0);
         tick();
      end
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir_req_addr", 32'(imem_req_addr), 32'd12);
      tick();
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
         if (instr_valid) begin
            seen = 1'b1;
            chk("redir_instr_pc", 32'(instr_pc), 32'd12);
         end
         tick();
      end
      chk("redir_instr_seen", 32'(seen), 32'd1);
      stream(8);

      // Fetch PC wrap 31 -> 0
      do_reset();
      drive(1'b1, 5'd31, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("wrap_req31", 32'(imem_req_addr), 32'd31);
      tick();
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wrap_req0", 32'(imem_req_addr), 32'd0);
      tick();
      stream(12);

      // Randomized traffic, redirects and occasional mid-run reset
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         drive(($urandom_range(0, 29) == 0), 5'($urandom),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 6));
         tick();
      end
      rst = 1'b0;
      stream(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
